// File: rtl/seq_alu_pkg.sv
// Shared types and constants for the sequential ALU core:
// opcode values, FSM states and the iterative-unit operation kinds.
package seq_alu_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_OPW   = 4;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_MUL  = 2;
    localparam int OP_DIV  = 3;
    localparam int OP_AND  = 4;
    localparam int OP_OR   = 5;
    localparam int OP_XOR  = 6;
    localparam int OP_NAND = 7;
    localparam int OP_NOR  = 8;
    localparam int OP_NOT  = 9;
    localparam int OP_MOD  = 10;
    localparam int OP_SHL  = 11;
    localparam int OP_SHR  = 12;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef enum logic [1:0] {IT_MUL, IT_DIV, IT_MOD} iter_kind_t;

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative datapath: WIDTH-step shift-add multiplier and restoring divider
// sharing one 2*WIDTH working register. Outputs show the value after the current step.
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               mode_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] work;
    logic [2*WIDTH-1:0] work_nxt;
    logic [WIDTH-1:0]   opnd;
    logic               div_q;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;

    // Multiply keeps {partial, multiplier} in work; divide keeps {remainder, quotient}.
    always_comb begin
        mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : '0);
        div_shift = work[2*WIDTH-1:WIDTH-1];
        div_ge    = div_shift >= {1'b0, opnd};
        div_diff  = div_shift - {1'b0, opnd};
        if (div_q) begin
            work_nxt = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        work[WIDTH-2:0], div_ge};
        end else begin
            work_nxt = {mul_sum, work[WIDTH-1:1]};
        end
    end

    assign done      = busy && (cnt == '0);
    assign product   = work_nxt;
    assign quotient  = work_nxt[WIDTH-1:0];
    assign remainder = work_nxt[2*WIDTH-1:WIDTH];

    // NOTE: sequential state uses non-blocking (<=) so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work  <= '0;
            opnd  <= '0;
            div_q <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= CW'(WIDTH - 1);
            div_q <= mode_div;
            opnd  <= mode_div ? b : a;
            work  <= {{WIDTH{1'b0}}, (mode_div ? a : b)};
        end else if (busy) begin
            work <= work_nxt;
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/seq_alu_core.sv
// Multi-cycle ALU with valid/ready on both sides; single-cycle ops computed at accept,
// MUL/DIV/MOD delegated to seq_alu_iter. Define ALU_ACC_EN to add the result accumulator.
module seq_alu_core
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OPW   = DEF_OPW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OPW-1:0]     op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               use_acc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               flag_zero,
    output logic               flag_neg,
    output logic               flag_err
);

    localparam logic [WIDTH:0] SH_LIM = (WIDTH + 1)'(2 * WIDTH);

    state_t             state;
    iter_kind_t         kind;
    logic               accept;
    logic [WIDTH-1:0]   a_eff;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] wide_a;
    logic [2*WIDTH-1:0] sc_res;
    logic               sc_err;
    logic               sc_neg;
    logic               sc_iter;
    iter_kind_t         sc_kind;
    logic               iter_busy;
    logic               iter_done;
    logic [2*WIDTH-1:0] iter_product;
    logic [WIDTH-1:0]   iter_quot;
    logic [WIDTH-1:0]   iter_rem;
    logic [2*WIDTH-1:0] iter_res;

`ifdef ALU_ACC_EN
    logic [WIDTH-1:0] acc;
    assign a_eff = use_acc ? acc : a;
`else
    logic unused_use_acc;
    assign unused_use_acc = use_acc;
    assign a_eff = a;
`endif

    // In DONE a new op can be taken in the same cycle the result is handed off.
    assign in_ready = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept   = in_valid && in_ready;
    assign wide_a   = {{WIDTH{1'b0}}, a_eff};

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        sc_res  = '0;
        sc_err  = 1'b0;
        sc_neg  = 1'b0;
        sc_iter = 1'b0;
        sc_kind = IT_MUL;
        diff    = {1'b0, a_eff} - {1'b0, b};
        case (32'(op))
            OP_ADD:  sc_res = wide_a + {{WIDTH{1'b0}}, b};
            OP_SUB:  begin
                sc_res = {{(WIDTH-1){diff[WIDTH]}}, diff};
                sc_neg = diff[WIDTH];
            end
            OP_MUL:  sc_iter = 1'b1;
            OP_DIV:  begin
                if (b == '0) begin
                    sc_res = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                    sc_err = 1'b1;
                end else begin
                    sc_iter = 1'b1;
                    sc_kind = IT_DIV;
                end
            end
            OP_MOD:  begin
                if (b == '0) begin
                    sc_res = wide_a;
                    sc_err = 1'b1;
                end else begin
                    sc_iter = 1'b1;
                    sc_kind = IT_MOD;
                end
            end
            OP_AND:  sc_res = {{WIDTH{1'b0}}, a_eff & b};
            OP_OR:   sc_res = {{WIDTH{1'b0}}, a_eff | b};
            OP_XOR:  sc_res = {{WIDTH{1'b0}}, a_eff ^ b};
            OP_NAND: sc_res = {{WIDTH{1'b0}}, ~(a_eff & b)};
            OP_NOR:  sc_res = {{WIDTH{1'b0}}, ~(a_eff | b)};
            OP_NOT:  sc_res = {{WIDTH{1'b0}}, ~a_eff};
            OP_SHL:  sc_res = ({1'b0, b} >= SH_LIM) ? '0 : (wide_a << b);
            OP_SHR:  sc_res = ({1'b0, b} >= SH_LIM) ? '0 : (wide_a >> b);
            default: sc_err = 1'b1;
        endcase
    end

    seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (accept && sc_iter),
        .mode_div  (sc_kind != IT_MUL),
        .a         (a_eff),
        .b         (b),
        .busy      (iter_busy),
        .done      (iter_done),
        .product   (iter_product),
        .quotient  (iter_quot),
        .remainder (iter_rem)
    );

    assign iter_res = (kind == IT_MUL) ? iter_product :
                      (kind == IT_DIV) ? {{WIDTH{1'b0}}, iter_quot} :
                                         {{WIDTH{1'b0}}, iter_rem};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            kind      <= IT_MUL;
            out_valid <= 1'b0;
            result    <= '0;
            flag_zero <= 1'b0;
            flag_neg  <= 1'b0;
            flag_err  <= 1'b0;
`ifdef ALU_ACC_EN
            acc       <= '0;
`endif
        end else begin
            case (state)
                BUSY: begin
                    if (iter_busy && iter_done) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= iter_res;
                        flag_zero <= (iter_res == '0);
                        flag_neg  <= 1'b0;
                        flag_err  <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
`ifdef ALU_ACC_EN
                        acc       <= result[WIDTH-1:0];
`endif
                    end
                end
                default: ;
            endcase
            // A same-cycle accept overrides the DONE->IDLE hand-off above.
            if (accept) begin
                if (sc_iter) begin
                    state <= BUSY;
                    kind  <= sc_kind;
                end else begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                    result    <= sc_res;
                    flag_zero <= (sc_res == '0);
                    flag_neg  <= sc_neg;
                    flag_err  <= sc_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_alu_core.sv
// Self-checking bench for seq_alu_core (WIDTH=8): directed, randomized, throughput,
// backpressure and reset-abort scenarios against an arithmetic reference model.
module tb_seq_alu_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        use_acc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        flag_zero;
    logic        flag_neg;
    logic        flag_err;

    int checks   = 0;
    int failures = 0;
    logic [7:0] acc_model = 8'h00;

`ifdef ALU_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    typedef struct {
        int         opc;
        int         av;
        int         bv;
        int         er;
        logic [2:0] ef;
        int         el;
        logic       ua;
    } vec_t;

    seq_alu_core #(.WIDTH(8), .OPW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .use_acc   (use_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_zero (flag_zero),
        .flag_neg  (flag_neg),
        .flag_err  (flag_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: result, flags {zero,neg,err} and latency straight from the opcode table.
    function automatic void model(input int opc, input int av, input int bv,
                                  output int r, output logic [2:0] fl, output int lat);
        bit err;
        err = 1'b0;
        lat = 1;
        case (opc)
            0:  r = av + bv;
            1:  r = (av - bv) & 'hFFFF;
            2:  begin r = av * bv; lat = 9; end
            3:  if (bv == 0) begin r = 255; err = 1'b1; end
                else begin r = av / bv; lat = 9; end
            4:  r = av & bv;
            5:  r = av | bv;
            6:  r = av ^ bv;
            7:  r = ~(av & bv) & 'hFF;
            8:  r = ~(av | bv) & 'hFF;
            9:  r = ~av & 'hFF;
            10: if (bv == 0) begin r = av; err = 1'b1; end
                else begin r = av % bv; lat = 9; end
            11: r = (bv >= 16) ? 0 : ((av << bv) & 'hFFFF);
            12: r = (bv >= 16) ? 0 : (av >> bv);
            default: begin r = 0; err = 1'b1; end
        endcase
        fl = {(r == 0), ((opc == 1) && (r >= 'h8000)), err};
    endfunction

    // Drives one operation with out_ready high; called and left on a falling edge.
    task automatic run_op(input int opc, input logic [7:0] aa, input logic [7:0] bb,
                          input logic ua, output int lat, output logic [15:0] res,
                          output logic [2:0] fl);
        int n;
        op = 4'(opc); a = aa; b = bb; use_acc = ua;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk); #1; n++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); use_acc = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk); lat++;
        end
        res = result;
        fl  = {flag_zero, flag_neg, flag_err};
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; use_acc = 1'b0;
        op = 4'd0; a = 8'd0; b = 8'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, result, flag_zero, flag_neg, flag_err} !== 20'd0) begin
            failures++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h flags=%b%b%b, want all 0",
                     in_ready, out_valid, result, flag_zero, flag_neg, flag_err);
        end
        rst_n = 1'b1; #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
        end
        acc_model = 8'h00;
    endtask

    task automatic test_directed();
        vec_t t [21] = '{
            '{2, 200, 3,   'h0258, 3'b000, 9, 1'b0},
            '{3, 200, 7,   'h001C, 3'b000, 9, 1'b0},
            '{10, 200, 7,  'h0004, 3'b000, 9, 1'b0},
            '{3, 200, 0,   'h00FF, 3'b001, 1, 1'b0},
            '{10, 200, 0,  'h00C8, 3'b001, 1, 1'b0},
            '{1, 3, 5,     'hFFFE, 3'b010, 1, 1'b0},
            '{0, 255, 1,   'h0100, 3'b000, 1, 1'b0},
            '{6, 'h5A, 'h5A, 0,    3'b100, 1, 1'b0},
            '{11, 1, 20,   0,      3'b100, 1, 1'b0},
            '{11, 'h81, 9, 'h0200, 3'b000, 1, 1'b0},
            '{11, 1, 15,   'h8000, 3'b000, 1, 1'b0},
            '{11, 1, 16,   0,      3'b100, 1, 1'b0},
            '{12, 'h80, 7, 1,      3'b000, 1, 1'b0},
            '{12, 'hFF, 16, 0,     3'b100, 1, 1'b0},
            '{9, 'h0F, 0,  'hF0,   3'b000, 1, 1'b0},
            '{7, 'hF0, 'h3C, 'hCF, 3'b000, 1, 1'b0},
            '{8, 0, 0,     'hFF,   3'b000, 1, 1'b0},
            '{14, 'h12, 'h34, 0,   3'b101, 1, 1'b0},
            '{2, 255, 255, 'hFE01, 3'b000, 9, 1'b0},
            '{3, 7, 200,   0,      3'b100, 9, 1'b0},
            '{1, 0, 0,     0,      3'b100, 1, 1'b0}
        };
        int lat;
        logic [15:0] res;
        logic [2:0] fl;
        for (int i = 0; i < 21; i++) begin
            run_op(t[i].opc, 8'(t[i].av), 8'(t[i].bv), t[i].ua, lat, res, fl);
            checks++;
            if ({res, fl} !== {16'(t[i].er), t[i].ef}) begin
                failures++;
                $display("FAIL directed[%0d] op=%0d a=%0d b=%0d: result=%h flags=%b want %h %b",
                         i, t[i].opc, t[i].av, t[i].bv, res, fl, 16'(t[i].er), t[i].ef);
            end
            checks++;
            if (lat !== t[i].el) begin
                failures++;
                $display("FAIL directed_latency[%0d] op=%0d: got %0d want %0d",
                         i, t[i].opc, lat, t[i].el);
            end
            acc_model = 8'(t[i].er);
        end
    endtask

    task automatic test_random();
        int opc, av, bv, ea, er, el, lat;
        logic ua;
        logic [2:0] ef, fl;
        logic [15:0] res;
        for (int i = 0; i < 60; i++) begin
            opc = $urandom_range(0, 15);
            av  = $urandom_range(0, 255);
            bv  = $urandom_range(0, 255);
            if (opc == 11 || opc == 12) bv = $urandom_range(0, 18);
            if ((opc == 3 || opc == 10) && $urandom_range(0, 4) == 0) bv = 0;
            ua  = 1'($urandom);
            ea  = (ACC_EN && ua) ? int'(acc_model) : av;
            model(opc, ea, bv, er, ef, el);
            run_op(opc, 8'(av), 8'(bv), ua, lat, res, fl);
            checks++;
            if ({res, fl, 8'(lat)} !== {16'(er), ef, 8'(el)}) begin
                failures++;
                $display("FAIL random[%0d] op=%0d a=%0d b=%0d acc=%0d: result=%h flags=%b lat=%0d want %h %b %0d",
                         i, opc, ea, bv, ua, res, fl, lat, 16'(er), ef, el);
            end
            acc_model = 8'(er);
        end
    endtask

    task automatic test_back_to_back();
        int sc_ops [13] = '{0, 1, 4, 5, 6, 7, 8, 9, 11, 12, 13, 14, 15};
        int opc, av, bv, er, el;
        logic [2:0] ef;
        out_ready = 1'b1;
        use_acc = 1'b0;
        for (int k = 0; k < 20; k++) begin
            opc = sc_ops[$urandom_range(0, 12)];
            av  = $urandom_range(0, 255);
            bv  = (opc == 11 || opc == 12) ? $urandom_range(0, 17) : $urandom_range(0, 255);
            model(opc, av, bv, er, ef, el);
            op = 4'(opc); a = 8'(av); b = 8'(bv); in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if ({out_valid, result, flag_zero, flag_neg, flag_err} !== {1'b1, 16'(er), ef}) begin
                failures++;
                $display("FAIL back_to_back[%0d] op=%0d: valid=%b result=%h flags=%b%b%b want 1 %h %b",
                         k, opc, out_valid, result, flag_zero, flag_neg, flag_err, 16'(er), ef);
            end
            acc_model = 8'(er);
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        op = 4'd0; a = 8'd2; b = 8'd2; use_acc = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        op = 4'd4; a = 8'hF0; b = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 16'h0004}) begin
                failures++;
                $display("FAIL stall[%0d]: out_valid=%b in_ready=%b result=%h want 1 0 0004",
                         i, out_valid, in_ready, result);
            end
            @(negedge clk);
        end
        out_ready = 1'b1; #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release_ready: in_ready=%b want 1", in_ready);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, result, flag_zero, flag_neg, flag_err} !== {1'b1, 16'h0030, 3'b000}) begin
            failures++;
            $display("FAIL queued_and: out_valid=%b result=%h flags=%b%b%b want 1 0030 000",
                     out_valid, result, flag_zero, flag_neg, flag_err);
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL queued_and_drain: out_valid=%b want 0", out_valid);
        end
        acc_model = 8'h30;
    endtask

    task automatic test_reset_mid_op();
        int seen;
        op = 4'd2; a = 8'd15; b = 8'd15; use_acc = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; #1;
        checks++;
        if ({out_valid, in_ready, result, flag_zero, flag_neg, flag_err} !== {1'b0, 1'b1, 16'h0000, 3'b000}) begin
            failures++;
            $display("FAIL reset_abort_state: out_valid=%b in_ready=%b result=%h want 0 1 0000",
                     out_valid, in_ready, result);
        end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid || result == 16'd225) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL reset_abort_stale: %0d cycles showed a result, want 0", seen);
        end
        acc_model = 8'h00;
    endtask

`ifdef ALU_ACC_EN
    task automatic test_acc();
        vec_t t [4] = '{
            '{0, 10, 5,    'h000F, 3'b000, 1, 1'b0},
            '{0, 'h77, 1,  'h0010, 3'b000, 1, 1'b1},
            '{1, 'h33, 20, 'hFFFC, 3'b010, 1, 1'b1},
            '{2, 'h05, 2,  'h01F8, 3'b000, 9, 1'b1}
        };
        int lat;
        logic [15:0] res;
        logic [2:0] fl;
        for (int i = 0; i < 4; i++) begin
            run_op(t[i].opc, 8'(t[i].av), 8'(t[i].bv), t[i].ua, lat, res, fl);
            checks++;
            if ({res, fl, 8'(lat)} !== {16'(t[i].er), t[i].ef, 8'(t[i].el)}) begin
                failures++;
                $display("FAIL acc_chain[%0d]: result=%h flags=%b lat=%0d want %h %b %0d",
                         i, res, fl, lat, 16'(t[i].er), t[i].ef, t[i].el);
            end
            acc_model = 8'(t[i].er);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_op();
`ifdef ALU_ACC_EN
        test_acc();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
